mmu_bus_ctrl: RTL and testbench

- Parametrised, clocked successor of the single-cycle address decoder.
- Sits between the CPU data port and ROM, synchronous RAM and the UART transmitter.
- Adds configurable region map, RAM wait-state handshake, a UART TX FIFO so CPU writes are never dropped while the UART is busy, and sticky bus-error reporting for unmapped accesses.

---
 rtl/mmu_bus_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mmu_bus_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_bus_ctrl.sv
// mmu_bus_ctrl: clocked CPU data-port bus controller.
// It decodes ROM, RAM and UART register regions, and adds a RAM wait-state
// handshake. UART bytes are buffered in a TX FIFO so CPU writes are not lost
// while the transmitter is busy. Any unmapped access or ROM write sets a
// sticky bus-error flag.
module mmu_bus_ctrl #(
    parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
    parameter logic [31:0] ROM_SIZE    = 32'h0000_2000,
    parameter logic [31:0] RAM_BASE    = 32'h0000_2000,
    parameter logic [31:0] RAM_SIZE    = 32'h0000_2000,
    parameter logic [31:0] IO_BASE     = 32'h0000_4000,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_from_cpu,
    input  logic        mem_read_cpu,
    input  logic        mem_write_cpu,
    output logic [31:0] data_to_cpu,
    output logic        ack_cpu,
    output logic        stall_cpu,
    input  logic [31:0] data_from_rom,
    input  logic [31:0] data_from_ram,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] data_to_ram,
    input  logic        uart_busy,
    output logic        uart_write,
    output logic [7:0]  uart_data,
    output logic        bus_error
);
    localparam int unsigned     PW      = (FIFO_DEPTH > 32'd1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CW      = PW + 1;
    localparam logic [31:0]     ROM_END = ROM_BASE + ROM_SIZE;
    localparam logic [31:0]     RAM_END = RAM_BASE + RAM_SIZE;
    localparam logic [2:0]      LAT     = 3'(RAM_LATENCY);
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RAM_WAIT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic            uart_write_q;
    logic [7:0]      uart_data_q;
    logic            bus_error_q;

    logic            req_wr_s, req_rd_s;
    logic            hit_rom_s, hit_ram_s, hit_data_s, hit_stat_s, hit_err_s;
    logic            full_s, empty_s, push_s, pop_s;
    logic            ack_s, ram_read_s, ram_write_s, set_err_s, clr_err_s;
    logic [31:0]     rdata_s, status_s;

    // A simultaneous read and write request is handled as a write.
    assign req_wr_s   = mem_write_cpu;
    assign req_rd_s   = mem_read_cpu & ~mem_write_cpu;
    assign hit_rom_s  = (addr >= ROM_BASE) && (addr < ROM_END);
    assign hit_ram_s  = (addr >= RAM_BASE) && (addr < RAM_END);
    assign hit_data_s = (addr == IO_BASE);
    assign hit_stat_s = (addr == (IO_BASE + 32'd4));
    assign hit_err_s  = (addr == (IO_BASE + 32'd8));

    assign full_s   = (count_q == DEPTH_C);
    assign empty_s  = (count_q == {CW{1'b0}});
    assign status_s = {21'd0, 8'(count_q), uart_busy, empty_s, full_s};
    // The holdoff on uart_write_q covers the cycle before the UART raises busy.
    assign pop_s    = ~empty_s & ~uart_busy & ~uart_write_q;

    // Next-state and access decode for the IDLE / RAM_WAIT handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_s       = 1'b0;
        rdata_s     = 32'd0;
        ram_read_s  = 1'b0;
        ram_write_s = 1'b0;
        push_s      = 1'b0;
        set_err_s   = 1'b0;
        clr_err_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_wr_s) begin
                    if (hit_rom_s) begin
                        ack_s     = 1'b1;
                        set_err_s = 1'b1;
                    end else if (hit_ram_s) begin
                        ack_s       = 1'b1;
                        ram_write_s = 1'b1;
                    end else if (hit_data_s) begin
                        ack_s  = ~full_s;
                        push_s = ~full_s;
                    end else if (hit_stat_s) begin
                        ack_s = 1'b1;
                    end else if (hit_err_s) begin
                        ack_s     = 1'b1;
                        clr_err_s = 1'b1;
                    end else begin
                        ack_s     = 1'b1;
                        set_err_s = 1'b1;
                    end
                end else if (req_rd_s) begin
                    if (hit_rom_s) begin
                        ack_s   = 1'b1;
                        rdata_s = data_from_rom;
                    end else if (hit_ram_s) begin
                        if (RAM_LATENCY == 32'd0) begin
                            ack_s   = 1'b1;
                            rdata_s = data_from_ram;
                        end else begin
                            ram_read_s = 1'b1;
                            cnt_d      = LAT;
                            state_d    = ST_RAM_WAIT;
                        end
                    end else if (hit_data_s) begin
                        ack_s = 1'b1;
                    end else if (hit_stat_s) begin
                        ack_s   = 1'b1;
                        rdata_s = status_s;
                    end else if (hit_err_s) begin
                        ack_s   = 1'b1;
                        rdata_s = {31'd0, bus_error_q};
                    end else begin
                        ack_s     = 1'b1;
                        set_err_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAM_WAIT: begin
                if (req_rd_s && hit_ram_s) begin
                    ram_read_s = 1'b1;
                    if (cnt_q == 3'd1) begin
                        ack_s   = 1'b1;
                        rdata_s = data_from_ram;
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // No ack or RAM strobe is allowed during a reset cycle.
    assign ack_cpu     = ack_s & ~rst;
    assign data_to_cpu = ack_cpu ? rdata_s : 32'd0;
    assign stall_cpu   = (mem_read_cpu | mem_write_cpu) & ~ack_cpu;
    assign ram_read    = ram_read_s & ~rst;
    assign ram_write   = ram_write_s & ~rst;
    assign data_to_ram = data_from_cpu;
    assign uart_write  = uart_write_q;
    assign uart_data   = uart_data_q;
    assign bus_error   = bus_error_q;

    // FSM state and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= data_from_cpu[7:0];
        end
    end

    // FIFO pointers, occupancy, UART load pulse and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            uart_write_q <= 1'b0;
            uart_data_q  <= 8'd0;
            bus_error_q  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q    <= rd_ptr_q + PW'(1);
                uart_data_q <= fifo_mem_q[rd_ptr_q];
            end
            count_q      <= count_q + CW'(push_s) - CW'(pop_s);
            uart_write_q <= pop_s;
            // A new error outranks a clear in the same cycle.
            if (set_err_s) begin
                bus_error_q <= 1'b1;
            end else if (clr_err_s) begin
                bus_error_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mmu_bus_ctrl.sv
// Self-checking bench for mmu_bus_ctrl with RAM_LATENCY=2 and FIFO_DEPTH=8.
module tb_mmu_bus_ctrl;
    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0000_2000;
    localparam logic [31:0] RAM_BASE = 32'h0000_2000;
    localparam logic [31:0] RAM_SIZE = 32'h0000_2000;
    localparam logic [31:0] IO_BASE  = 32'h0000_4000;
    localparam int          LATENCY  = 2;
    localparam int          DEPTH    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data_from_cpu, data_from_rom, data_from_ram;
    logic        mem_read_cpu, mem_write_cpu, uart_busy;
    logic [31:0] data_to_cpu, data_to_ram;
    logic        ack_cpu, stall_cpu, ram_read, ram_write, uart_write, bus_error;
    logic [7:0]  uart_data;

    int checks = 0;
    int errors = 0;

    // results of the last access() call
    int          acc_cyc, acc_stalls, acc_rr;
    logic [31:0] acc_data, acc_wdr;
    logic        acc_rw;

    // UART pulse monitor
    logic [7:0]  got_q[$];
    int          b2b = 0;
    logic        prev_uw = 1'b0;

    mmu_bus_ctrl #(
        .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE), .RAM_BASE(RAM_BASE),
        .RAM_SIZE(RAM_SIZE), .IO_BASE(IO_BASE), .RAM_LATENCY(LATENCY),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_from_cpu(data_from_cpu),
        .mem_read_cpu(mem_read_cpu), .mem_write_cpu(mem_write_cpu),
        .data_to_cpu(data_to_cpu), .ack_cpu(ack_cpu), .stall_cpu(stall_cpu),
        .data_from_rom(data_from_rom), .data_from_ram(data_from_ram),
        .ram_read(ram_read), .ram_write(ram_write), .data_to_ram(data_to_ram),
        .uart_busy(uart_busy), .uart_write(uart_write), .uart_data(uart_data),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_write) begin
            got_q.push_back(uart_data);
            if (prev_uw) b2b++;
        end
        prev_uw = uart_write;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Issue one request (called 1 time unit after a rising edge); hold it until
    // ack or a cycle budget expires, then drop it one cycle later.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        acc_cyc = -1; acc_stalls = 0; acc_rr = 0; acc_data = 32'd0;
        acc_wdr = 32'd0; acc_rw = 1'b0;
        addr = a; data_from_cpu = wd; mem_write_cpu = wr; mem_read_cpu = ~wr;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ram_read) acc_rr++;
            if (stall_cpu) acc_stalls++;
            if (ack_cpu) begin
                acc_cyc = n; acc_data = data_to_cpu;
                acc_rw = ram_write; acc_wdr = data_to_ram;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_read_cpu = 1'b0; mem_write_cpu = 1'b0;
    endtask

    task automatic test_reset();
        addr = 32'h10; data_from_rom = 32'hDEAD_BEEF; mem_read_cpu = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ack_cpu !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_cpu); end
        checks++; if (data_to_cpu !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", data_to_cpu); end
        checks++; if (uart_write !== 1'b0 || uart_data !== 8'd0) begin errors++; $display("FAIL reset_uart: got %b/%h want 0/00", uart_write, uart_data); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_error); end
        @(posedge clk); #1;
        rst = 1'b0; mem_read_cpu = 1'b0;
        @(posedge clk); #1;
        access(1'b0, IO_BASE + 32'd4, 32'd0);
        checks++; if (acc_data !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h want 00000002", acc_data); end
    endtask

    task automatic test_rom();
        logic [31:0] a, d;
        data_from_rom = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0010, 32'd0);
        checks++; if (acc_cyc !== 0 || acc_stalls !== 0) begin errors++; $display("FAIL rom_latency: got cyc %0d stalls %0d want 0 0", acc_cyc, acc_stalls); end
        checks++; if (acc_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rom_data: got %h want deadbeef", acc_data); end
        for (int i = 0; i < 4; i++) begin
            a = ROM_BASE + (($urandom % ROM_SIZE) & 32'hFFFF_FFFC);
            d = $urandom; data_from_rom = d;
            access(1'b0, a, 32'd0);
            checks++; if (acc_cyc !== 0 || acc_data !== d) begin errors++; $display("FAIL rom_rand: addr %h got cyc %0d data %h want 0 %h", a, acc_cyc, acc_data, d); end
        end
    endtask

    task automatic test_ram();
        logic [31:0] a, d;
        data_from_ram = 32'h1234_5678;
        access(1'b0, 32'h0000_2004, 32'd0);
        checks++; if (acc_cyc !== LATENCY) begin errors++; $display("FAIL ram_latency: got %0d want %0d", acc_cyc, LATENCY); end
        checks++; if (acc_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_data: got %h want 12345678", acc_data); end
        checks++; if (acc_stalls !== LATENCY) begin errors++; $display("FAIL ram_stall: got %0d want %0d", acc_stalls, LATENCY); end
        checks++; if (acc_rr !== LATENCY + 1) begin errors++; $display("FAIL ram_read_len: got %0d want %0d", acc_rr, LATENCY + 1); end
        for (int i = 0; i < 4; i++) begin
            a = RAM_BASE + ($urandom % RAM_SIZE);
            d = $urandom; data_from_ram = d;
            access(1'b0, a, 32'd0);
            checks++; if (acc_cyc !== LATENCY || acc_data !== d) begin errors++; $display("FAIL ram_rand: addr %h got cyc %0d data %h want %0d %h", a, acc_cyc, acc_data, LATENCY, d); end
        end
        d = $urandom;
        access(1'b1, RAM_BASE + 32'h100, d);
        checks++; if (acc_cyc !== 0 || acc_rw !== 1'b1 || acc_wdr !== d) begin errors++; $display("FAIL ram_write: got cyc %0d strobe %b data %h want 0 1 %h", acc_cyc, acc_rw, acc_wdr, d); end
        // request dropped mid-wait: no ack, controller back in IDLE
        addr = RAM_BASE + 32'h40; mem_read_cpu = 1'b1;
        @(posedge clk); #1;
        mem_read_cpu = 1'b0;
        @(negedge clk);
        checks++; if (ack_cpu !== 1'b0 || ram_read !== 1'b0) begin errors++; $display("FAIL ram_abort: got ack %b ram_read %b want 0 0", ack_cpu, ram_read); end
        @(posedge clk); #1;
        data_from_rom = 32'hA5A5_0001;
        access(1'b0, 32'h0000_0020, 32'd0);
        checks++; if (acc_cyc !== 0 || acc_data !== 32'hA5A5_0001) begin errors++; $display("FAIL ram_abort_idle: got cyc %0d data %h want 0 a5a50001", acc_cyc, acc_data); end
    endtask

    task automatic test_err();
        access(1'b0, 32'h8000_0000, 32'd0);
        checks++; if (acc_cyc !== 0 || acc_data !== 32'd0) begin errors++; $display("FAIL unmapped_read: got cyc %0d data %h want 0 0", acc_cyc, acc_data); end
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus_error); end
        access(1'b0, IO_BASE + 32'd8, 32'd0);
        checks++; if (acc_data !== 32'd1) begin errors++; $display("FAIL err_read: got %h want 1", acc_data); end
        access(1'b1, IO_BASE + 32'd8, 32'd0);
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus_error); end
        access(1'b0, IO_BASE + 32'd8, 32'd0);
        checks++; if (acc_data !== 32'd0) begin errors++; $display("FAIL err_read0: got %h want 0", acc_data); end
        access(1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
        checks++; if (acc_cyc !== 0 || bus_error !== 1'b1) begin errors++; $display("FAIL rom_write_err: got cyc %0d err %b want 0 1", acc_cyc, bus_error); end
        access(1'b1, IO_BASE + 32'd8, 32'd0);
    endtask

    task automatic test_uart_single();
        uart_busy = 1'b0; got_q.delete(); b2b = 0;
        access(1'b1, IO_BASE, 32'hABCD_EF55);
        checks++; if (acc_cyc !== 0) begin errors++; $display("FAIL single_ack: got %0d want 0", acc_cyc); end
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (got_q.size() !== 1 || b2b !== 0) begin errors++; $display("FAIL single_pulses: got %0d pulses b2b %0d want 1 0", got_q.size(), b2b); end
        checks++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h55) begin errors++; $display("FAIL single_byte: got %h want 55", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        access(1'b0, IO_BASE + 32'd4, 32'd0);
        checks++; if (acc_data !== 32'h0000_0002) begin errors++; $display("FAIL single_status: got %h want 00000002", acc_data); end
    endtask

    task automatic test_uart_fifo();
        int stalled, bad;
        uart_busy = 1'b1; got_q.delete(); b2b = 0;
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, IO_BASE, {24'($urandom), 8'h41 + 8'(i)});
            checks++; if (acc_cyc !== 0) begin errors++; $display("FAIL fifo_push%0d: got cyc %0d want 0", i, acc_cyc); end
        end
        access(1'b0, IO_BASE + 32'd4, 32'd0);
        checks++; if (acc_data !== 32'h0000_0045) begin errors++; $display("FAIL fifo_full_status: got %h want 00000045", acc_data); end
        addr = IO_BASE; data_from_cpu = 32'h0000_0049; mem_write_cpu = 1'b1;
        stalled = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (stall_cpu && !ack_cpu) stalled++;
            @(posedge clk); #1;
        end
        checks++; if (stalled !== 4) begin errors++; $display("FAIL fifo_full_stall: got %0d stalled cycles want 4", stalled); end
        uart_busy = 1'b0;
        @(negedge clk);
        checks++; if (ack_cpu !== 1'b0) begin errors++; $display("FAIL fifo_ack_early: got %b want 0", ack_cpu); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ack_cpu !== 1'b1 || uart_write !== 1'b1) begin errors++; $display("FAIL fifo_ninth_ack: got ack %b uart_write %b want 1 1", ack_cpu, uart_write); end
        @(posedge clk); #1;
        mem_write_cpu = 1'b0;
        for (int n = 0; n < 60 && got_q.size() < 9; n++) begin @(posedge clk); #1; end
        checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL fifo_drain_count: got %0d want 9", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < 9; i++) if (got_q[i] !== 8'h41 + 8'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL fifo_order: got %0d out-of-order bytes want 0", bad); end
        checks++; if (b2b !== 0) begin errors++; $display("FAIL fifo_b2b: got %0d back-to-back pulses want 0", b2b); end
    endtask

    // Random accesses against a region-level model; UART kept busy so the
    // FIFO occupancy equals the model queue length.
    task automatic test_random();
        logic [7:0]  mq[$];
        logic        exp_err, wr;
        logic [31:0] a, d, exp_d;
        int          r, exp_cyc, bad;
        uart_busy = 1'b1; got_q.delete(); b2b = 0;
        access(1'b1, IO_BASE + 32'd8, 32'd0);
        exp_err = 1'b0;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 5); wr = 1'($urandom_range(0, 1));
            d = $urandom; exp_d = 32'd0;
            data_from_rom = $urandom; data_from_ram = $urandom;
            case (r)
                0: begin a = ROM_BASE + ($urandom % ROM_SIZE); exp_d = data_from_rom; end
                1: begin a = RAM_BASE + ($urandom % RAM_SIZE); exp_d = data_from_ram; end
                2: begin a = IO_BASE; if (mq.size() == DEPTH) wr = 1'b0; end
                3: begin
                    a = IO_BASE + 32'd4;
                    exp_d = (32'(mq.size()) << 3) | 32'd4 | ((mq.size() == 0) ? 32'd2 : 32'd0)
                          | ((mq.size() == DEPTH) ? 32'd1 : 32'd0);
                end
                4: begin a = IO_BASE + 32'd8; exp_d = {31'd0, exp_err}; end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h0001_0000 + ($urandom % 32'h00FF_0000);
                        1: a = 32'h0000_400C + 32'($urandom_range(0, 15)) * 32'd4;
                        2: a = 32'h0000_4001 + 32'($urandom_range(0, 2));
                        default: a = 32'h8000_0000 | $urandom;
                    endcase
                end
            endcase
            exp_cyc = (r == 1 && !wr) ? LATENCY : 0;
            access(wr, a, d);
            if (wr && (r == 0 || r == 5)) exp_err = 1'b1;
            if (wr && r == 4) exp_err = 1'b0;
            if (!wr && (r == 0 || r == 5)) exp_err = (r == 5) ? 1'b1 : exp_err;
            if (wr && r == 2) mq.push_back(d[7:0]);
            checks++; if (acc_cyc !== exp_cyc) begin errors++; $display("FAIL rand_latency: addr %h wr %b got %0d want %0d", a, wr, acc_cyc, exp_cyc); end
            if (!wr) begin
                checks++; if (acc_data !== exp_d) begin errors++; $display("FAIL rand_data: addr %h got %h want %h", a, acc_data, exp_d); end
            end
            checks++; if (bus_error !== exp_err) begin errors++; $display("FAIL rand_err: addr %h wr %b got %b want %b", a, wr, bus_error, exp_err); end
        end
        uart_busy = 1'b0;
        for (int n = 0; n < 60 && got_q.size() < mq.size(); n++) begin @(posedge clk); #1; end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (got_q.size() !== mq.size()) begin errors++; $display("FAIL rand_drain_count: got %0d want %0d", got_q.size(), mq.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < mq.size(); i++) if (got_q[i] !== mq[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_drain_data: got %0d wrong bytes want 0", bad); end
    endtask

    task automatic test_reset_mid();
        uart_busy = 1'b1;
        for (int i = 0; i < 3; i++) access(1'b1, IO_BASE, 32'h60 + 32'(i));
        addr = RAM_BASE + 32'h10; data_from_ram = 32'hCAFE_F00D; mem_read_cpu = 1'b1;
        @(negedge clk);
        checks++; if (ram_read !== 1'b1) begin errors++; $display("FAIL mid_ram_read: got %b want 1", ram_read); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ack_cpu !== 1'b0 || data_to_cpu !== 32'd0) begin errors++; $display("FAIL mid_reset_ack: got ack %b data %h want 0 0", ack_cpu, data_to_cpu); end
        @(posedge clk); #1;
        rst = 1'b0; mem_read_cpu = 1'b0; uart_busy = 1'b0; got_q.delete();
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_no_uart: got %0d pulses want 0", got_q.size()); end
        access(1'b0, IO_BASE + 32'd4, 32'd0);
        checks++; if (acc_data !== 32'h0000_0002) begin errors++; $display("FAIL mid_status: got %h want 00000002", acc_data); end
    endtask

    initial begin
        rst = 1'b1; addr = 32'd0; data_from_cpu = 32'd0; data_from_rom = 32'd0;
        data_from_ram = 32'd0; mem_read_cpu = 1'b0; mem_write_cpu = 1'b0; uart_busy = 1'b0;
        test_reset();
        test_rom();
        test_ram();
        test_err();
        test_uart_single();
        test_uart_fifo();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
